tl_phase_scheduler: RTL

//  Phase sequencer for the traffic-light intersection. It steps RED -> YEL_RG -> GREEN -> YEL_GR -> RED
//  on a 1 Hz tick strobe and runs from run-time programmable phase durations.
//  It drives the active-low lamps and the remaining-seconds count, split into BCD digits for the

---
 rtl/tl_pkg.sv | 38 +++
 rtl/tl_bin2bcd.sv | 21 ++
 rtl/tl_phase_scheduler.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// -----------------------------------------------------------------------------
// tl_pkg
// Shared types and constants for the traffic-light phase scheduler.
//   phase_t      : phase encoding, also driven out on the scheduler's phase port
//   LED_*        : active-low lamp patterns ([0] red, [1] yellow, [2] green, [3] unused)
//   CFG_SEL_*    : duration-register select codes for configuration writes
//   MAX_DUR      : largest programmable phase duration, seconds
//   cfg_val_ok() : a duration write is legal only for values 1..MAX_DUR
// -----------------------------------------------------------------------------
package tl_pkg;

  typedef enum logic [2:0] {
    NIGHT  = 3'b000,
    GREEN  = 3'b001,
    YEL_RG = 3'b010,
    YEL_GR = 3'b011,
    RED    = 3'b100
  } phase_t;

  localparam logic [3:0] LED_RED   = 4'b1110;
  localparam logic [3:0] LED_YEL   = 4'b1101;
  localparam logic [3:0] LED_GRN   = 4'b1011;
  localparam logic [3:0] LED_OFF   = 4'b1111;
  // XOR mask that flips only the yellow lamp
  localparam logic [3:0] LED_BLINK = 4'b0010;

  localparam logic [1:0] CFG_SEL_RED  = 2'd0;
  localparam logic [1:0] CFG_SEL_YEL  = 2'd1;
  localparam logic [1:0] CFG_SEL_GRN  = 2'd2;
  localparam logic [1:0] CFG_SEL_RSVD = 2'd3;

  localparam logic [6:0] MAX_DUR = 7'd99;

  function automatic logic cfg_val_ok(input logic [6:0] val);
    return (val != 7'd0) && (val <= MAX_DUR);
  endfunction

endpackage

// File: rtl/tl_bin2bcd.sv
// -----------------------------------------------------------------------------
// tl_bin2bcd
// Combinational 7-bit binary to two BCD digits for the seven-segment path.
// Intended input range is 0..99.
//   bin  in  7  binary value
//   tens out 4  bin / 10
//   ones out 4  bin % 10
// -----------------------------------------------------------------------------
module tl_bin2bcd (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  // Constant divisor: synthesis reduces this to a small comparator/subtractor net.
  always_comb begin
    tens = 4'(bin / 7'd10);
    ones = 4'(bin % 7'd10);
  end

endmodule

// File: rtl/tl_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tl_phase_scheduler
// Traffic-light phase sequencer: RED -> YEL_RG -> GREEN -> YEL_GR -> RED, one
// step per 1 Hz tick, with programmable durations, night (flashing yellow)
// mode and optional pedestrian shortening of GREEN.
// Optional feature macro: TL_PED_REQ_EN (pedestrian request handling).
// Ports:
//   clk          in   1  system clock
//   rst_n        in   1  synchronous active-low reset
//   tick_1hz     in   1  one-clk enable strobe per second
//   night_req    in   1  night mode request level
//   ped_req      in   1  pedestrian request pulse
//   cfg_we       in   1  duration write strobe
//   cfg_sel      in   2  0=RED 1=YEL 2=GRN 3=reserved
//   cfg_val      in   7  new duration, seconds
//   phase        out  3  current phase
//   remain       out  7  seconds left in current phase
//   remain_tens  out  4  remain / 10
//   remain_ones  out  4  remain % 10
//   led          out  4  active-low lamps
//   ped_ack      out  1  pulse when a pedestrian request is accepted
// -----------------------------------------------------------------------------
module tl_phase_scheduler
  import tl_pkg::*;
#(
  parameter logic [6:0] T_RED_DEF = 7'd25,
  parameter logic [6:0] T_YEL_DEF = 7'd5,
  parameter logic [6:0] T_GRN_DEF = 7'd30,
  parameter logic [6:0] PED_MIN   = 7'd5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       night_req,
  input  logic       ped_req,
  input  logic       cfg_we,
  input  logic [1:0] cfg_sel,
  input  logic [6:0] cfg_val,
  output phase_t     phase,
  output logic [6:0] remain,
  output logic [3:0] remain_tens,
  output logic [3:0] remain_ones,
  output logic [3:0] led,
  output logic       ped_ack
);

  phase_t     state_q, state_d;
  logic [6:0] remain_q, remain_d;
  logic [3:0] led_q, led_d;
  logic [6:0] t_red_q, t_red_d;
  logic [6:0] t_yel_q, t_yel_d;
  logic [6:0] t_grn_q, t_grn_d;
  logic [6:0] entry_dur_s;
  logic [3:0] entry_led_s;
  logic       ped_force_s;

  // State, countdown and lamp registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RED;
      remain_q <= T_RED_DEF;
      led_q    <= LED_RED;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      led_q    <= led_d;
    end
  end

  // Next-state logic: every transition is gated by the tick; night has priority
  always_comb begin
    state_d = state_q;
    if (tick_1hz) begin
      if (night_req) begin
        state_d = NIGHT;
      end else begin
        case (state_q)
          NIGHT:   state_d = RED;
          RED:     state_d = (remain_q == 7'd1) ? YEL_RG : RED;
          YEL_RG:  state_d = (remain_q == 7'd1) ? GREEN  : YEL_RG;
          GREEN:   state_d = (remain_q == 7'd1) ? YEL_GR : GREEN;
          YEL_GR:  state_d = (remain_q == 7'd1) ? RED    : YEL_GR;
          default: state_d = RED;
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // Duration and lamp pattern loaded on entry to the next phase (old register values)
  always_comb begin
    entry_dur_s = t_red_q;
    entry_led_s = LED_RED;
    case (state_d)
      RED:     begin entry_dur_s = t_red_q; entry_led_s = LED_RED; end
      YEL_RG:  begin entry_dur_s = t_yel_q; entry_led_s = LED_YEL; end
      GREEN:   begin entry_dur_s = t_grn_q; entry_led_s = LED_GRN; end
      YEL_GR:  begin entry_dur_s = t_yel_q; entry_led_s = LED_YEL; end
      NIGHT:   begin entry_dur_s = 7'd0;    entry_led_s = LED_YEL; end
      default: begin entry_dur_s = t_red_q; entry_led_s = LED_RED; end
    endcase
  end

  // Output logic: countdown and lamp updates on each tick
  always_comb begin
    remain_d = remain_q;
    led_d    = led_q;
    if (tick_1hz) begin
      if (state_d != state_q) begin
        remain_d = entry_dur_s;
        led_d    = entry_led_s;
      end else if (state_q == NIGHT) begin
        remain_d = 7'd0;
        led_d    = led_q ^ LED_BLINK;
      end else if (ped_force_s) begin
        remain_d = PED_MIN;
        led_d    = led_q;
      end else begin
        // Staying in a normal phase implies remain_q > 1, so no underflow.
        remain_d = remain_q - 7'd1;
        if ((state_q == YEL_RG) || (state_q == YEL_GR)) begin
          led_d = led_q ^ LED_BLINK;
        end else begin
          led_d = led_q;
        end
      end
    end else begin
      remain_d = remain_q;
      led_d    = led_q;
    end
  end

  // Duration register write decode; reserved select and out-of-range values are dropped
  always_comb begin
    t_red_d = t_red_q;
    t_yel_d = t_yel_q;
    t_grn_d = t_grn_q;
    if (cfg_we && cfg_val_ok(cfg_val)) begin
      case (cfg_sel)
        CFG_SEL_RED:  t_red_d = cfg_val;
        CFG_SEL_YEL:  t_yel_d = cfg_val;
        CFG_SEL_GRN:  t_grn_d = cfg_val;
        CFG_SEL_RSVD: t_red_d = t_red_q;
        default:      t_red_d = t_red_q;
      endcase
    end else begin
      t_red_d = t_red_q;
    end
  end

  // Duration registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_red_q <= T_RED_DEF;
      t_yel_q <= T_YEL_DEF;
      t_grn_q <= T_GRN_DEF;
    end else begin
      t_red_q <= t_red_d;
      t_yel_q <= t_yel_d;
      t_grn_q <= t_grn_d;
    end
  end

`ifdef TL_PED_REQ_EN
  logic ped_lat_q, ped_lat_d;
  logic ped_ack_q, ped_ack_d;
  logic ped_accept_s;

  // Pedestrian accept/latch: a tick consumes the latch; entering night clears it
  always_comb begin
    ped_accept_s = ped_req && (state_q == GREEN) && (remain_q > PED_MIN) &&
                   !ped_lat_q && !(tick_1hz && night_req);
    ped_force_s  = tick_1hz && ped_lat_q && (remain_q > PED_MIN);
    ped_ack_d    = ped_accept_s;
    if (tick_1hz && night_req) begin
      ped_lat_d = 1'b0;
    end else if (ped_accept_s) begin
      ped_lat_d = 1'b1;
    end else if (tick_1hz) begin
      ped_lat_d = 1'b0;
    end else begin
      ped_lat_d = ped_lat_q;
    end
  end

  // Pedestrian latch and acknowledge registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ped_lat_q <= 1'b0;
      ped_ack_q <= 1'b0;
    end else begin
      ped_lat_q <= ped_lat_d;
      ped_ack_q <= ped_ack_d;
    end
  end

  assign ped_ack = ped_ack_q;
`else
  // Feature absent: request input and threshold intentionally unused.
  logic [7:0] ped_unused;
  assign ped_unused  = {ped_req, PED_MIN};
  assign ped_force_s = 1'b0;
  assign ped_ack     = 1'b0;
`endif

  assign phase  = state_q;
  assign remain = remain_q;
  assign led    = led_q;

  tl_bin2bcd u_bcd (
    .bin  (remain_q),
    .tens (remain_tens),
    .ones (remain_ones)
  );

endmodule
